// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipe consumer side.
package pipe_pkg;

  localparam int PIPE_N     = 10;
  localparam int PIPE_LAT   = 3;
  localparam int PIPE_TAG_W = 8;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_drain_fifo.sv
// Synchronous result FIFO with a registered head; no empty-to-output bypass.
module pipe_drain_fifo
  import pipe_pkg::*;
#(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next, kept;
  logic [W-1:0]  head_reg;
  logic          pop_ok;

  assign pop_ok = pop && (count_reg != '0);

  always_comb begin
    rd_ptr_next = rd_ptr_reg + AW'(pop_ok);
    kept        = count_reg - CW'(pop_ok);
    count_next  = kept + CW'(push);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_data;
  end

  // The head register follows the entry at the new read pointer; when the
  // FIFO drained to empty on this edge the incoming word becomes the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (count_next != '0)
        head_reg <= (kept == '0) ? push_data : mem[rd_ptr_next];
    end
  end

  assign head  = head_reg;
  assign count = count_reg;

endmodule

// File: rtl/pipe_result_drain.sv
// Captures pipe results LAT cycles after each valid issue and meters issue credit.
// Optional issue tagging is enabled with macro PIPE_RESULT_DRAIN_TAG_EN.
module pipe_result_drain
  import pipe_pkg::*;
#(
  parameter int N     = PIPE_N,
  parameter int LAT   = PIPE_LAT,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       issue_ready,
  input  logic [N-1:0]               F,
  output logic [N-1:0]               out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
`ifdef PIPE_RESULT_DRAIN_TAG_EN
  output logic [PIPE_TAG_W-1:0]      out_tag,
`endif
  output logic [$clog2(DEPTH+1)-1:0] inflight,
  output logic                       drop_err
);

  localparam int CW = cnt_w(DEPTH);
`ifdef PIPE_RESULT_DRAIN_TAG_EN
  localparam int W = N + PIPE_TAG_W;
`else
  localparam int W = N;
`endif

  logic [LAT:1]  vld_reg, vld_next;
  logic          accept, tap, pop;
  logic [CW-1:0] inflight_reg, fifo_count;
  logic [CW:0]   credit_sum;
  logic          drop_err_reg;
  logic [W-1:0]  push_data, head;

  assign accept = in_valid && issue_ready;
  assign tap    = vld_reg[LAT];

  assign vld_next[1] = accept;
  for (genvar gi = 2; gi <= LAT; gi++) begin : g_vld
    assign vld_next[gi] = vld_reg[gi-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_reg      <= '0;
      inflight_reg <= '0;
      drop_err_reg <= 1'b0;
    end else begin
      vld_reg      <= vld_next;
      inflight_reg <= inflight_reg + CW'(accept) - CW'(tap);
      if (in_valid && !issue_ready) drop_err_reg <= 1'b1;
    end
  end

  // Credit counts results already promised to the FIFO; a same-cycle pop
  // is deliberately not credited so a capture can never find it full.
  assign credit_sum  = {1'b0, inflight_reg} + {1'b0, fifo_count};
  assign issue_ready = credit_sum < (CW+1)'(DEPTH);

`ifdef PIPE_RESULT_DRAIN_TAG_EN
  logic [PIPE_TAG_W-1:0] tag_cnt_reg;
  logic [PIPE_TAG_W-1:0] tag_reg  [1:LAT];
  logic [PIPE_TAG_W-1:0] tag_next [1:LAT];

  assign tag_next[1] = tag_cnt_reg;
  for (genvar gi = 2; gi <= LAT; gi++) begin : g_tag
    assign tag_next[gi] = tag_reg[gi-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_cnt_reg <= '0;
      for (int i = 1; i <= LAT; i++) tag_reg[i] <= '0;
    end else begin
      if (accept) tag_cnt_reg <= tag_cnt_reg + 8'd1;
      tag_reg <= tag_next;
    end
  end

  assign push_data = {tag_reg[LAT], F};
  assign out_tag   = head[W-1:N];
`else
  assign push_data = F;
`endif

  assign pop = out_valid && out_ready;

  pipe_drain_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tap),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign out_data  = head[N-1:0];
  assign out_valid = (fifo_count != '0);
  assign count     = fifo_count;
  assign inflight  = inflight_reg;
  assign drop_err  = drop_err_reg;

endmodule
